// File: rtl/ip_hdr_stream_insert.sv
// ip_hdr_stream_insert
//   Prepends a checksummed 20-byte IPv4 header to a payload stream. The output
//   is one contiguous MSB-first byte stream, realigned across bus beats, and
//   feeds the Ethernet/MAC framing stage. A per-packet timestamp travels with
//   every output beat.
//
// Ports
//   clk, rst                   clock, asynchronous active-low reset
//   src_insert_hdr_val/...     header + timestamp input (valid/ready)
//   insert_src_hdr_rdy         header accepted
//   src_insert_data_*          payload beats, byte 0 at MSB, padbytes on last
//   insert_src_data_rdy        payload beat accepted
//   insert_dst_data_*          realigned output beats (valid/ready)
//   insert_dst_timestamp       packet timestamp, constant for a whole packet
//   dst_insert_data_rdy        downstream ready
//   dbg_state_o                current FSM state (IDLE/ZERO/STREAM/DRAIN)
//
// Handshake: a transfer happens on a clock edge where valid && ready are both
// high. Valid never depends on ready; ready may depend on valid-free state.

package ip_hdr_stream_insert_pkg;

  typedef struct packed {
    logic [3:0]  version;
    logic [3:0]  ihl;
    logic [7:0]  tos;
    logic [15:0] tot_len;
    logic [15:0] id;
    logic [2:0]  flags;
    logic [12:0] frag_off;
    logic [7:0]  ttl;
    logic [7:0]  protocol;
    logic [15:0] checksum;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
  } ip_pkt_hdr;

  typedef struct packed {
    logic [31:0] sec;
    logic [31:0] nsec;
  } tracker_stats_struct;

endpackage

module ip_hdr_stream_insert
  import ip_hdr_stream_insert_pkg::*;
#(
  parameter int DATA_W     = 256,
  parameter int DATA_BYTES = DATA_W / 8,
  parameter int PAD_W      = $clog2(DATA_BYTES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                src_insert_hdr_val,
  input  ip_pkt_hdr           src_insert_ip_hdr,
  input  tracker_stats_struct src_insert_timestamp,
  output logic                insert_src_hdr_rdy,
  input  logic                src_insert_data_val,
  input  logic [DATA_W-1:0]   src_insert_data,
  input  logic                src_insert_data_last,
  input  logic [PAD_W-1:0]    src_insert_data_padbytes,
  output logic                insert_src_data_rdy,
  output logic                insert_dst_data_val,
  output logic [DATA_W-1:0]   insert_dst_data,
  output logic                insert_dst_data_last,
  output logic [PAD_W-1:0]    insert_dst_data_padbytes,
  output tracker_stats_struct insert_dst_timestamp,
  input  logic                dst_insert_data_rdy,
  output logic [1:0]          dbg_state_o
);

  localparam int HDR_BYTES = 20;
  localparam int HDR_W     = HDR_BYTES * 8;
  localparam int C_BYTES   = DATA_BYTES - HDR_BYTES;
  localparam int C_W       = C_BYTES * 8;
  localparam int CNT_W     = PAD_W + 1;

  localparam logic [CNT_W-1:0] DB_L     = CNT_W'(DATA_BYTES);
  localparam logic [CNT_W-1:0] C_L      = CNT_W'(C_BYTES);
  localparam logic [CNT_W-1:0] HDR_L    = CNT_W'(HDR_BYTES);
  localparam logic [15:0]      ZERO_LEN = 16'(HDR_BYTES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ZERO   = 2'd1,
    S_STREAM = 2'd2,
    S_DRAIN  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                run_q;
  logic [HDR_W-1:0]    carry_q;
  tracker_stats_struct ts_q;
  logic [CNT_W-1:0]    drain_q;

  logic                out_val_q;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_last_q, out_last_d;
  logic [PAD_W-1:0]    out_pad_q, out_pad_d;
  tracker_stats_struct out_ts_q;
  logic                out_load;

  logic                ld_ok;
  logic                hdr_rdy, data_rdy;
  logic                hdr_fire, data_fire;
  logic [CNT_W-1:0]    beat_v;
  logic                beat_big;

  // Mask that keeps the top n bytes of a beat and clears the rest.
  function automatic logic [DATA_W-1:0] keep_top(input logic [CNT_W-1:0] n);
    logic [CNT_W+2:0] sh;
    sh = {n, 3'b000};
    return ~({DATA_W{1'b1}} >> sh);
  endfunction

  // out_reg may take a new beat when empty or when it drains this cycle.
  assign ld_ok     = !out_val_q || dst_insert_data_rdy;
  assign hdr_fire  = src_insert_hdr_val && hdr_rdy;
  assign data_fire = src_insert_data_val && data_rdy;

  // Valid bytes of the current input beat.
  assign beat_v   = src_insert_data_last ? (DB_L - {1'b0, src_insert_data_padbytes}) : DB_L;
  // Last beat whose bytes do not all fit behind the carried 20 bytes.
  assign beat_big = src_insert_data_last && (beat_v > C_L);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (hdr_fire) begin
          state_d = (src_insert_ip_hdr.tot_len == ZERO_LEN) ? S_ZERO : S_STREAM;
        end
      end
      S_ZERO: begin
        if (ld_ok) state_d = S_IDLE;
      end
      S_STREAM: begin
        if (data_fire && src_insert_data_last) begin
          state_d = beat_big ? S_DRAIN : S_IDLE;
        end
      end
      S_DRAIN: begin
        if (ld_ok) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: source readies and the next out_reg contents
  always_comb begin
    hdr_rdy    = 1'b0;
    data_rdy   = 1'b0;
    out_load   = 1'b0;
    out_data_d = '0;
    out_last_d = 1'b0;
    out_pad_d  = '0;
    case (state_q)
      S_IDLE: begin
        // run_q keeps the header ready low until the first edge after reset.
        hdr_rdy = run_q && ld_ok;
      end
      S_ZERO: begin
        out_load   = ld_ok;
        out_data_d = {carry_q, {C_W{1'b0}}};
        out_last_d = 1'b1;
        out_pad_d  = C_L[PAD_W-1:0];
      end
      S_STREAM: begin
        data_rdy   = ld_ok;
        out_load   = data_fire;
        out_data_d = {carry_q, src_insert_data[DATA_W-1 -: C_W]};
        if (src_insert_data_last && !beat_big) begin
          // Packet ends in this beat: clear the bytes beyond header + V.
          out_data_d = out_data_d & keep_top(HDR_L + beat_v);
          out_last_d = 1'b1;
          out_pad_d  = PAD_W'(C_L - beat_v);
        end
      end
      S_DRAIN: begin
        out_load   = ld_ok;
        out_data_d = {carry_q, {C_W{1'b0}}} & keep_top(drain_q);
        out_last_d = 1'b1;
        out_pad_d  = PAD_W'(DB_L - drain_q);
      end
      default: ;
    endcase
  end

  // Carry, timestamp and output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q      <= 1'b0;
      carry_q    <= '0;
      ts_q       <= '0;
      drain_q    <= '0;
      out_val_q  <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      out_pad_q  <= '0;
      out_ts_q   <= '0;
    end else begin
      run_q <= 1'b1;
      if (hdr_fire) begin
        carry_q <= src_insert_ip_hdr;
        ts_q    <= src_insert_timestamp;
      end else if (data_fire) begin
        // The low 20 bytes ride into the next output beat.
        carry_q <= src_insert_data[HDR_W-1:0];
        drain_q <= beat_v - C_L;
      end
      if (out_load) begin
        out_val_q  <= 1'b1;
        out_data_q <= out_data_d;
        out_last_q <= out_last_d;
        out_pad_q  <= out_pad_d;
        out_ts_q   <= ts_q;
      end else if (dst_insert_data_rdy) begin
        out_val_q <= 1'b0;
      end
    end
  end

  assign insert_src_hdr_rdy       = hdr_rdy;
  assign insert_src_data_rdy      = data_rdy;
  assign insert_dst_data_val      = out_val_q;
  assign insert_dst_data          = out_data_q;
  assign insert_dst_data_last     = out_last_q;
  assign insert_dst_data_padbytes = out_pad_q;
  assign insert_dst_timestamp     = out_ts_q;
  assign dbg_state_o              = state_q;

endmodule

// File: tb/tb_ip_hdr_stream_insert.sv
module tb_ip_hdr_stream_insert;
  import ip_hdr_stream_insert_pkg::*;

  localparam int DATA_W = 256;
  localparam int DB     = 32;
  localparam int PAD_W  = 5;
  localparam int EW     = 1 + PAD_W + 64 + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                hdr_val;
  ip_pkt_hdr           hdr;
  tracker_stats_struct tstamp;
  logic                hdr_rdy;
  logic                data_val;
  logic [DATA_W-1:0]   data;
  logic                data_last;
  logic [PAD_W-1:0]    data_pad;
  logic                data_rdy;
  logic                out_val;
  logic [DATA_W-1:0]   out_data;
  logic                out_last;
  logic [PAD_W-1:0]    out_pad;
  tracker_stats_struct out_ts;
  logic                dst_rdy;
  logic [1:0]          dbg_state;

  ip_hdr_stream_insert #(.DATA_W(DATA_W)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .src_insert_hdr_val       (hdr_val),
    .src_insert_ip_hdr        (hdr),
    .src_insert_timestamp     (tstamp),
    .insert_src_hdr_rdy       (hdr_rdy),
    .src_insert_data_val      (data_val),
    .src_insert_data          (data),
    .src_insert_data_last     (data_last),
    .src_insert_data_padbytes (data_pad),
    .insert_src_data_rdy      (data_rdy),
    .insert_dst_data_val      (out_val),
    .insert_dst_data          (out_data),
    .insert_dst_data_last     (out_last),
    .insert_dst_data_padbytes (out_pad),
    .insert_dst_timestamp     (out_ts),
    .dst_insert_data_rdy      (dst_rdy),
    .dbg_state_o              (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [EW-1:0] exp_q[$];
  int done_beats_q[$];
  int done_pad_q[$];
  logic [DATA_W-1:0] cap [0:3];
  int cap_idx = 0;
  bit mon_en = 1'b1;
  bit rand_rdy = 1'b0;
  bit data_rdy_seen = 1'b0;
  bit prev_stall = 1'b0;
  logic [DATA_W+PAD_W:0] prev_obs;
  logic [EW-1:0] e;
  byte unsigned pay[$];
  ip_pkt_hdr cur_hdr;
  int hdr_acc_cyc = 0;
  int data_acc_cyc = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] byte_at(input logic [DATA_W-1:0] d, input int k);
    return d[DATA_W-1-8*k -: 8];
  endfunction

  // ---------------- reference model ----------------
  // Stream-level view: header bytes then payload bytes, cut into 32-byte beats.
  task automatic push_expected(input logic [159:0] h, input logic [63:0] ts);
    byte unsigned all[$];
    int tot;
    int nb;
    logic [DATA_W-1:0] d;
    for (int k = 0; k < 20; k++) all.push_back(h[159-8*k -: 8]);
    foreach (pay[k]) all.push_back(pay[k]);
    tot = all.size();
    nb  = (tot + DB - 1) / DB;
    for (int b = 0; b < nb; b++) begin
      d = '0;
      for (int k = 0; k < DB; k++)
        if (b*DB + k < tot) d[DATA_W-1-8*k -: 8] = all[b*DB + k];
      exp_q.push_back({(b == nb-1), (b == nb-1) ? PAD_W'(nb*DB - tot) : PAD_W'(0), ts, d});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic build_pkt(input int len, input bit fixed);
    pay.delete();
    for (int k = 0; k < len; k++)
      pay.push_back(fixed ? 8'(k + 1) : 8'($urandom_range(0, 255)));
    cur_hdr.version  = 4'd4;
    cur_hdr.ihl      = 4'd5;
    cur_hdr.tos      = fixed ? 8'h00 : 8'($urandom_range(0, 255));
    cur_hdr.tot_len  = 16'(20 + len);
    cur_hdr.id       = fixed ? 16'h1234 : 16'($urandom);
    cur_hdr.flags    = 3'b010;
    cur_hdr.frag_off = 13'd0;
    cur_hdr.ttl      = 8'd64;
    cur_hdr.protocol = 8'd17;
    cur_hdr.checksum = fixed ? 16'hbeef : 16'($urandom);
    cur_hdr.src_addr = 32'h0a000001;
    cur_hdr.dst_addr = fixed ? 32'h0a000002 : $urandom;
  endtask

  task automatic send_hdr(input logic [63:0] ts);
    bit ok = 1'b0;
    hdr_val = 1'b1;
    hdr     = cur_hdr;
    tstamp  = ts;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (hdr_rdy) begin
        ok = 1'b1;
        hdr_acc_cyc = cyc;
        break;
      end
    end
    chk("hdr_accept", 512'(ok), 512'(1));
    @(posedge clk);
    #1;
    hdr_val = 1'b0;
  endtask

  task automatic send_beat(input logic [DATA_W-1:0] d, input bit last, input logic [PAD_W-1:0] pad);
    bit ok = 1'b0;
    data_val  = 1'b1;
    data      = d;
    data_last = last;
    data_pad  = pad;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (data_rdy) begin
        ok = 1'b1;
        data_acc_cyc = cyc;
        break;
      end
    end
    chk("data_accept", 512'(ok), 512'(1));
    @(posedge clk);
    #1;
    data_val = 1'b0;
  endtask

  // Padded bytes are driven as 0xEE so output zeroing is exercised.
  task automatic send_payload(input int len);
    int nb = (len + DB - 1) / DB;
    for (int b = 0; b < nb; b++) begin
      logic [DATA_W-1:0] d;
      int pad;
      for (int k = 0; k < DB; k++)
        d[DATA_W-1-8*k -: 8] = (b*DB + k < len) ? pay[b*DB + k] : 8'hEE;
      pad = (b == nb-1) ? nb*DB - len : 0;
      send_beat(d, b == nb-1, PAD_W'(pad));
    end
  endtask

  task automatic send_pkt(input int len, input logic [63:0] ts, input bit fixed);
    build_pkt(len, fixed);
    push_expected(cur_hdr, ts);
    send_hdr(ts);
    if (len > 0) send_payload(len);
  endtask

  task automatic wait_empty(input int budget);
    for (int k = 0; k < budget && exp_q.size() != 0; k++) @(posedge clk);
    #2;
    chk("drain_done", 512'(exp_q.size()), 512'(0));
  endtask

  task automatic check_pkt(input int beats, input int pad);
    if (done_beats_q.size() == 0) begin
      chk("pkt_done", 512'(0), 512'(1));
    end else begin
      chk("pkt_beats", 512'(done_beats_q.pop_front()), 512'(beats));
      chk("pkt_pad", 512'(done_pad_q.pop_front()), 512'(pad));
    end
  endtask

  // ---------------- ready generator / cycle counter ----------------
  initial begin
    dst_rdy = 1'b1;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      dst_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (data_rdy) data_rdy_seen = 1'b1;
      if (!mon_en) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_val", 512'(out_val), 512'(1));
          chk("stall_hold", 512'({out_last, out_pad, out_data}), 512'(prev_obs));
        end
        if (out_val && dst_rdy) begin
          if (exp_q.size() == 0) begin
            chk("extra_beat", 512'(1), 512'(0));
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", 512'(out_data), 512'(e[DATA_W-1:0]));
            chk("beat_ts", 512'(out_ts), 512'(e[DATA_W+63:DATA_W]));
            chk("beat_last", 512'(out_last), 512'(e[EW-1]));
            chk("beat_pad", 512'(out_pad), 512'(e[EW-2 -: PAD_W]));
          end
          if (cap_idx < 4) cap[cap_idx] = out_data;
          cap_idx++;
          if (out_last) begin
            done_beats_q.push_back(cap_idx);
            done_pad_q.push_back(int'(out_pad));
            cap_idx = 0;
          end
        end
        prev_stall = out_val && !dst_rdy;
        prev_obs   = {out_last, out_pad, out_data};
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int d12;
    logic [DATA_W-1:0] d0;
    hdr_val   = 1'b0;
    hdr       = '0;
    tstamp    = '0;
    data_val  = 1'b0;
    data      = '0;
    data_last = 1'b0;
    data_pad  = '0;

    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_val", 512'(out_val), 512'(0));
    chk("rst_last", 512'(out_last), 512'(0));
    chk("rst_pad", 512'(out_pad), 512'(0));
    chk("rst_data", 512'(out_data), 512'(0));
    chk("rst_ts", 512'(out_ts), 512'(0));
    chk("rst_hdr_rdy", 512'(hdr_rdy), 512'(0));
    chk("rst_data_rdy", 512'(data_rdy), 512'(0));
    @(posedge clk);
    #1 rst = 1'b1;

    // Zero payload: header only, pad 12, data ready never raised.
    data_rdy_seen = 1'b0;
    send_pkt(0, 64'h0000_0001_0000_0010, 1'b1);
    wait_empty(200);
    check_pkt(1, 12);
    chk("zero_hdr", 512'(cap[0][255:96]), 512'(cur_hdr));
    chk("zero_tail", 512'(cap[0][95:0]), 512'(0));
    chk("zero_no_data_rdy", 512'(data_rdy_seen), 512'(0));

    // 8-byte payload.
    send_pkt(8, 64'h0000_0002_0000_0020, 1'b1);
    wait_empty(200);
    check_pkt(1, 4);
    chk("p8_b20", 512'(byte_at(cap[0], 20)), 512'(8'd1));
    chk("p8_b27", 512'(byte_at(cap[0], 27)), 512'(8'd8));
    chk("p8_b28", 512'(byte_at(cap[0], 28)), 512'(8'd0));

    // 12-byte payload followed at once by another packet.
    send_pkt(12, 64'h0000_0003_0000_0030, 1'b1);
    d12 = data_acc_cyc;
    send_pkt(8, 64'h0000_0003_0000_0031, 1'b1);
    wait_empty(200);
    check_pkt(1, 0);
    check_pkt(1, 4);
    chk("p12_next_hdr_gap", 512'(hdr_acc_cyc - d12), 512'(1));

    // 40-byte payload: two output beats.
    send_pkt(40, 64'h0000_0004_0000_0040, 1'b1);
    wait_empty(200);
    check_pkt(2, 4);
    chk("p40_b0_31", 512'(byte_at(cap[0], 31)), 512'(8'd12));
    chk("p40_b1_0", 512'(byte_at(cap[1], 0)), 512'(8'd13));
    chk("p40_b1_27", 512'(byte_at(cap[1], 27)), 512'(8'd40));
    chk("p40_b1_28", 512'(byte_at(cap[1], 28)), 512'(8'd0));

    // 64-byte payload: third beat comes from the drain state.
    send_pkt(64, 64'hA5A5_0005_0000_0050, 1'b1);
    wait_empty(200);
    check_pkt(3, 12);
    chk("p64_b2_0", 512'(byte_at(cap[2], 0)), 512'(8'd45));
    chk("p64_b2_19", 512'(byte_at(cap[2], 19)), 512'(8'd64));
    chk("p64_b2_20", 512'(byte_at(cap[2], 20)), 512'(8'd0));

    // Reset in the middle of a 100-byte packet.
    mon_en = 1'b0;
    build_pkt(100, 1'b1);
    send_hdr(64'h0000_dead_0000_beef);
    for (int k = 0; k < DB; k++) d0[DATA_W-1-8*k -: 8] = pay[k];
    send_beat(d0, 1'b0, '0);
    rst = 1'b0;
    #1;
    chk("mid_rst_val", 512'(out_val), 512'(0));
    chk("mid_rst_data", 512'(out_data), 512'(0));
    chk("mid_rst_last", 512'(out_last), 512'(0));
    chk("mid_rst_ts", 512'(out_ts), 512'(0));
    chk("mid_rst_hdr_rdy", 512'(hdr_rdy), 512'(0));
    chk("mid_rst_data_rdy", 512'(data_rdy), 512'(0));
    exp_q.delete();
    done_beats_q.delete();
    done_pad_q.delete();
    cap_idx = 0;
    @(posedge clk);
    #1 rst = 1'b1;
    mon_en = 1'b1;
    send_pkt(40, 64'h0000_0006_0000_0060, 1'b1);
    wait_empty(200);
    check_pkt(2, 4);
    chk("restart_b1_0", 512'(byte_at(cap[1], 0)), 512'(8'd13));

    // Random lengths with downstream ready toggling.
    rand_rdy = 1'b1;
    for (int p = 0; p < 100; p++)
      send_pkt($urandom_range(0, 1480), {$urandom, $urandom}, 1'b0);
    wait_empty(5000);
    rand_rdy = 1'b0;
    chk("rand_pkt_count", 512'(done_beats_q.size()), 512'(100));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
